// File: rtl/sampling_trigger.sv
// Capture-window sequencer for the DDR/FML sampling stage: arms, qualifies a bus
// trigger, holds start_stop high for WINDOW cycles, then holds off before re-arming.
module sampling_trigger #(
    parameter int unsigned WINDOW  = 32,
    parameter int unsigned HOLDOFF = 4096,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             arm,
    input  logic             abort,
    input  logic             continuous,
    input  logic [1:0]       trig_mode,
    input  logic             stb,
    input  logic             we,
    input  logic             ack,
    output logic             start_stop,
    output logic             armed,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] trig_count
);

    localparam int unsigned SPAN = (WINDOW > HOLDOFF) ? WINDOW : HOLDOFF;
    localparam int unsigned CW   = (SPAN > 1) ? $clog2(SPAN) : 1;

    localparam logic [CW-1:0] WIN_LOAD  = CW'(WINDOW - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_HOLD    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]  trig_count_q, trig_count_d;
    logic              stb_q;
    logic              done_d;
    logic              start_stop_q, armed_q, busy_q, done_q;
    logic              trig_hit_c;

    // Trigger qualification; only consulted while ARMED.
    always_comb begin
        trig_hit_c = 1'b0;
        case (trig_mode)
            2'd0:    trig_hit_c = 1'b1;
            2'd1:    trig_hit_c = stb & ~stb_q;
            2'd2:    trig_hit_c = stb & we & ack;
            default: trig_hit_c = stb & ~we & ack;
        endcase
    end

    // Next state, shared window/holdoff down-counter and trigger count.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        trig_count_d = trig_count_q;
        done_d       = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (trig_hit_c) begin
                        state_d = S_CAPTURE;
                        cnt_d   = WIN_LOAD;
                        if (!(&trig_count_q)) begin
                            trig_count_d = trig_count_q + CNT_W'(1);
                        end
                    end
                end
                S_CAPTURE: begin
                    if (cnt_q == '0) begin
                        state_d = S_HOLD;
                        cnt_d   = HOLD_LOAD;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt_q == '0) begin
                        state_d = continuous ? S_ARMED : S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            trig_count_q <= '0;
            stb_q        <= 1'b0;
            start_stop_q <= 1'b0;
            armed_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            trig_count_q <= trig_count_d;
            stb_q        <= stb;
            start_stop_q <= (state_d == S_CAPTURE);
            armed_q      <= (state_d == S_ARMED);
            busy_q       <= (state_d == S_CAPTURE) || (state_d == S_HOLD);
            done_q       <= done_d;
        end
    end

    assign start_stop = start_stop_q;
    assign armed      = armed_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign trig_count = trig_count_q;

endmodule

// File: tb/tb_sampling_trigger.sv
// Bench for sampling_trigger: directed scenarios plus randomized bus traffic,
// checked every cycle against a trigger-age based reference model.
module tb_sampling_trigger;

    localparam int unsigned WIN   = 32;
    localparam int unsigned HOLD  = 8;
    localparam int unsigned CW    = 3;
    localparam int          CMAX  = 7;

    localparam int M_IDLE   = 0;
    localparam int M_ARMED  = 1;
    localparam int M_ACTIVE = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm = 1'b0, abort = 1'b0, continuous = 1'b0;
    logic [1:0]    trig_mode = 2'd0;
    logic          stb = 1'b0, we = 1'b0, ack = 1'b0;
    logic          start_stop, armed, busy, done;
    logic [CW-1:0] trig_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: where we are, and how many cycles since start_stop rose.
    int m_st = M_IDLE;
    int m_age = 0;
    int m_cnt = 0;
    bit m_stb_prev = 1'b0;

    sampling_trigger #(.WINDOW(WIN), .HOLDOFF(HOLD), .CNT_W(CW)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .arm       (arm),
        .abort     (abort),
        .continuous(continuous),
        .trig_mode (trig_mode),
        .stb       (stb),
        .we        (we),
        .ack       (ack),
        .start_stop(start_stop),
        .armed     (armed),
        .busy      (busy),
        .done      (done),
        .trig_count(trig_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_st = M_IDLE;
        m_age = 0;
        m_cnt = 0;
        m_stb_prev = 1'b0;
    endtask

    task automatic model_step();
        bit hit;
        case (trig_mode)
            2'd0:    hit = 1'b1;
            2'd1:    hit = stb && !m_stb_prev;
            2'd2:    hit = stb && we && ack;
            default: hit = stb && !we && ack;
        endcase
        if (abort) begin
            m_st = M_IDLE;
        end else if (m_st == M_IDLE) begin
            if (arm) m_st = M_ARMED;
        end else if (m_st == M_ARMED) begin
            if (hit) begin
                m_st = M_ACTIVE;
                m_age = 0;
                if (m_cnt < CMAX) m_cnt++;
            end
        end else begin
            if (m_age == int'(WIN + HOLD) - 1) m_st = continuous ? M_ARMED : M_IDLE;
            m_age++;
        end
        m_stb_prev = stb;
    endtask

    // One clock: advance the model with the inputs now applied, then compare.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("start_stop", 32'(start_stop), 32'(m_st == M_ACTIVE && m_age < int'(WIN)));
        chk("armed", 32'(armed), 32'(m_st == M_ARMED));
        chk("busy", 32'(busy), 32'(m_st == M_ACTIVE));
        chk("done", 32'(done), 32'(m_st == M_ACTIVE && m_age == int'(WIN)));
        chk("trig_count", 32'(trig_count), 32'(m_cnt));
    endtask

    task automatic idle_inputs();
        arm = 1'b0; abort = 1'b0; continuous = 1'b0;
        trig_mode = 2'd0; stb = 1'b0; we = 1'b0; ack = 1'b0;
    endtask

    // Asserts reset between clock edges and checks outputs clear with no edge.
    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_start_stop", 32'(start_stop), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_trig_count", 32'(trig_count), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        int ss_cnt, first_ss, done_at, idle_at, rise0, rise1;
        bit prev_ss;

        #1;
        apply_reset();

        // Immediate trigger: arm observed at k=0, window k=1..32, done k=33, idle k=41.
        for (int i = 0; i < 8; i++) tick();
        arm_pulse();
        chk("imm_armed", 32'(armed), 32'd1);
        ss_cnt = 0; first_ss = -1; done_at = -1; idle_at = -1;
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (start_stop) begin
                ss_cnt++;
                if (first_ss < 0) first_ss = k;
            end
            if (done) done_at = k;
            if (idle_at < 0 && k > 1 && !busy && !armed) idle_at = k;
        end
        chk("imm_ss_len", 32'(ss_cnt), 32'd32);
        chk("imm_ss_first", 32'(first_ss), 32'd1);
        chk("imm_done_at", 32'(done_at), 32'd33);
        chk("imm_idle_at", 32'(idle_at), 32'd41);
        chk("imm_count", 32'(trig_count), 32'd1);

        // Edge trigger: stb high before arming must not count as an edge.
        apply_reset();
        trig_mode = 2'd1;
        stb = 1'b1;
        tick(); tick();
        arm_pulse();
        for (int i = 0; i < 5; i++) tick();
        chk("edge_no_trig", 32'(start_stop), 32'd0);
        stb = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        stb = 1'b1;
        tick();
        chk("edge_trig", 32'(start_stop), 32'd1);
        chk("edge_count", 32'(trig_count), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;

        // Read/write qualification, mode 2 then mode 3.
        apply_reset();
        trig_mode = 2'd2;
        arm_pulse();
        stb = 1; we = 0; ack = 1; tick();
        chk("m2_rd", 32'(start_stop), 32'd0);
        stb = 1; we = 1; ack = 0; tick();
        chk("m2_noack", 32'(start_stop), 32'd0);
        stb = 1; we = 1; ack = 1; tick();
        chk("m2_wr", 32'(start_stop), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        trig_mode = 2'd3;
        stb = 0; we = 0; ack = 0;
        arm_pulse();
        stb = 1; we = 1; ack = 1; tick();
        chk("m3_wr", 32'(start_stop), 32'd0);
        stb = 1; we = 0; ack = 0; tick();
        chk("m3_noack", 32'(start_stop), 32'd0);
        stb = 1; we = 0; ack = 1; tick();
        chk("m3_rd", 32'(start_stop), 32'd1);
        chk("m3_count", 32'(trig_count), 32'd2);

        // Abort at window cycle 5.
        apply_reset();
        arm_pulse();
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("abort_pre", 32'(start_stop), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_ss", 32'(start_stop), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_count", 32'(trig_count), 32'd1);
        done_at = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) done_at++;
        end
        chk("abort_no_done", 32'(done_at), 32'd0);
        arm_pulse();
        chk("abort_rearm", 32'(armed), 32'd1);
        tick();
        chk("abort_retrig", 32'(trig_count), 32'd2);

        // Continuous, mode 0: period WIN+HOLD+1, count saturates at 7.
        apply_reset();
        continuous = 1'b1;
        arm_pulse();
        rise0 = -1; rise1 = -1; prev_ss = 1'b0;
        for (int k = 0; k < 10 * 41; k++) begin
            tick();
            if (start_stop && !prev_ss) begin
                if (rise0 < 0) rise0 = k;
                else if (rise1 < 0) rise1 = k;
            end
            prev_ss = start_stop;
        end
        chk("cont_period", 32'(rise1 - rise0), 32'(WIN + HOLD + 1));
        chk("cont_sat", 32'(trig_count), 32'd7);

        // Randomized traffic.
        apply_reset();
        for (int k = 0; k < 4000; k++) begin
            arm   = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 63) == 0) continuous = ~continuous;
            if ($urandom_range(0, 63) == 0) trig_mode = 2'($urandom_range(0, 3));
            stb = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            ack = 1'($urandom_range(0, 1));
            tick();
        end

        // Async reset during CAPTURE, then stays idle until armed.
        idle_inputs();
        abort = 1'b1; tick(); abort = 1'b0;
        continuous = 1'b1;
        arm_pulse();
        for (int i = 0; i < 6; i++) tick();
        chk("ar_in_capture", 32'(start_stop), 32'd1);
        apply_reset();
        trig_mode = 2'd0;
        continuous = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("ar_idle_busy", 32'(busy), 32'd0);
        chk("ar_idle_armed", 32'(armed), 32'd0);
        arm_pulse();
        tick();
        chk("ar_rearm", 32'(start_stop), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
